adc_capture_dma_tx: RTL and testbench
=====================================

# adc_capture_dma_tx

Captures a triggered window of 128-bit ADC sample beats into an on-chip buffer, then streams it to the CPU as a 16-bit AXI-Stream DMA packet with `tlast`. It sits beside the experiment top level on the ADC side: it taps an ADC stream (MAC or NL) and drives the S2MM DMA channel. It is the return path for the 16-bit CPU-to-fabric DMA input.

## Interface
- `LANES`, default 8: 16-bit samples per ADC beat; the ADC data width is `16*LANES`.
- `DEPTH`, default 256: buffer capacity in ADC beats; must be a power of two.
- `AW`, default 8: buffer address width, equal to log2(`DEPTH`).

Ports:
- `clk` in 1: single clock, 250 MHz. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `trig` in 1: capture request; sampled only in IDLE.
- `cfg_len` in `AW+1`: capture length in ADC beats; latched when a trigger is accepted.
- `s_axis_tdata` in `16*LANES`: ADC beat. Lane k occupies bits [16k+15:16k].
- `s_axis_tvalid` in 1: ADC beat valid.
- `s_axis_tready` out 1: held at constant 1, because the ADC cannot be back-pressured.
- `m_axis_tdata` out 16: DMA word.
- `m_axis_tvalid` out 1: DMA word valid.
- `m_axis_tready` in 1: DMA ready.
- `m_axis_tlast` out 1: marks the final word of the packet.
- `busy` out 1: high when the FSM is not in IDLE.
- `done` out 1: one-cycle pulse after the last word handshake.
- `trig_err` out 1: one-cycle pulse when a trigger is rejected.

## Operation
- FSM states are IDLE, CAPTURE and DRAIN.
- **IDLE**
  - On `trig`=1 with `cfg_len`≠0: latch `len = min(cfg_len, DEPTH)`, clear the write pointer and go to CAPTURE.
  - On `trig`=1 with `cfg_len`=0: pulse `trig_err` and stay in IDLE.
- **CAPTURE**
  - Every cycle with `s_axis_tvalid`=1 writes the beat to `buf[wptr]` and increments `wptr`.
  - Cycles with `tvalid`=0 are skipped and nothing is written.
  - When the write of beat `len-1` occurs, go to DRAIN.
- **DRAIN**
  - Beats are read in order 0..`len-1`.
  - Within each beat, words are emitted lane 0 first through lane `LANES-1`.
  - A packet is `len*LANES` words. `m_axis_tlast`=1 only on the final word.
  - After the final handshake, pulse `done` and return to IDLE.
- A `trig` received in CAPTURE or DRAIN is ignored, pulses `trig_err`, and does not affect the current packet.
- ADC beats arriving in IDLE or DRAIN are discarded.
- `rst` mid-operation:
  - Next state is IDLE and all outputs return to their reset values.
  - Buffer contents are not cleared but are never emitted.
  - No partial packet or `tlast` is produced after reset.
- Buffer is an inferable simple-dual-port RAM with 1-cycle registered read. Drain uses a `16*LANES`-bit holding register plus a lane index of width log2(`LANES`).
- The next beat is prefetched while the current beat is being emitted, so throughput is sustained at 1 word/cycle.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `busy`, `done` and `trig_err` are 0.
  - `m_axis_tdata` is 0.
  - `s_axis_tready` is 1 at all times.
- Trigger accepted at edge t gives `busy`=1 from t+1. The first beat eligible for capture is the one presented in cycle t+1.
- Last capture write at edge c gives the first `m_axis_tvalid`=1 at cycle c+2 (state change plus RAM read latency).
- AXIS master rules:
  - Once `tvalid`=1, `tdata` and `tlast` are held stable until the `tvalid && tready` handshake.
  - `tvalid` never drops without a handshake, except on `rst`.
- With `m_axis_tready` held high, consecutive words are emitted on consecutive cycles, including across beat boundaries. A full packet takes `len*LANES` cycles.
- Final handshake at edge f: `done`=1 during cycle f+1, `busy`=0 from f+1, and `m_axis_tvalid`=0 from f+1.
  - A new `trig` is accepted at the earliest at cycle f+1.
- `trig_err` is asserted 1 cycle after the rejected `trig`.

## Test plan
- **Basic capture.** `cfg_len`=2, `trig` pulse. Beat0 has lane k = 0x0100+k; beat1 has lane k = 0x0200+k. `tready`=1.
  - Required: 16 consecutive words 0x0100..0x0107, 0x0200..0x0207.
  - `tlast` only on 0x0207, then a `done` pulse.
- **Gapped input and backpressure.** `cfg_len`=3, with `s_axis_tvalid` toggling 1/0. `m_axis_tready` random at 50%.
  - Required: exactly the 3 valid beats are captured, in order, as 24 words with no loss or duplication.
  - `tdata` is stable while `tvalid && !tready`.
- **Trigger while busy.** Assert `trig` again during CAPTURE and again during DRAIN.
  - Required: a `trig_err` pulse for each, and the packet is unchanged at 8*`len` words.
- **Length limits.**
  - `cfg_len`=0 gives a `trig_err` pulse, `busy` stays 0, and no output.
  - `cfg_len`=300 with `DEPTH`=256 gives exactly 2048 words, with `tlast` on word 2048.
- **Reset mid-drain.** Assert `rst` for 1 cycle after 5 words of a `len`=4 packet.
  - Required: the next cycle has `tvalid`=0 and `busy`=0, and no `done`.
  - A new `trig` with `len`=1 yields 8 words with fresh data and `tlast` on the 8th.

Source files
------------

// File: rtl/adc_capture_dma_tx.sv
// adc_capture_dma_tx: captures a triggered window of ADC beats and drains it as a 16-bit AXI-Stream packet
module adc_capture_dma_tx #(
    parameter int LANES = 8,
    parameter int DEPTH = 256,
    parameter int AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig,
    input  logic [AW:0]           cfg_len,
    input  logic [16*LANES-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  trig_err
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t state, state_n;
    logic [AW:0] len, wptr, obeat;
    logic [AW-1:0] rptr, raddr;
    logic [LW-1:0] lane;
    logic [16*LANES-1:0] mem [DEPTH];
    logic [16*LANES-1:0] rd_q, hold;
    logic accept, wr, fire, last_word, beat_end, first, re, done_n, err_n;

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = hold[16*lane +: 16];
    assign m_axis_tlast  = m_axis_tvalid && last_word;
    assign busy          = state != IDLE;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // Next state and per-cycle strobes; the first DRAIN cycle is the one where tvalid is still low
    always_comb begin
        accept    = state == IDLE && trig && cfg_len != '0;
        wr        = state == CAPTURE && s_axis_tvalid;
        fire      = m_axis_tvalid && m_axis_tready;
        last_word = lane == LANE_LAST && obeat == len - ONE;
        beat_end  = fire && lane == LANE_LAST;
        first     = state == DRAIN && !m_axis_tvalid;
        re        = first || beat_end;
        raddr     = first ? AW'(1) : rptr;
        done_n    = fire && last_word;
        err_n     = trig && !accept;
        state_n   = accept ? CAPTURE :
                    (wr && wptr == len - ONE) ? DRAIN :
                    done_n ? IDLE : state;
    end

    // Capture counters and drain pipeline; beat 0 goes straight into the holding register during capture
    // so the RAM only has to prefetch beats 1.. while the current beat is being emitted
    always_ff @(posedge clk) begin
        if (rst) begin
            len           <= '0;
            wptr          <= '0;
            obeat         <= '0;
            rptr          <= '0;
            lane          <= '0;
            hold          <= '0;
            m_axis_tvalid <= 1'b0;
            done          <= 1'b0;
            trig_err      <= 1'b0;
        end else begin
            done     <= done_n;
            trig_err <= err_n;
            if (accept) begin
                len  <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                wptr <= '0;
            end
            if (wr) wptr <= wptr + ONE;
            if (wr && wptr == '0) hold <= s_axis_tdata;
            if (first) begin
                m_axis_tvalid <= 1'b1;
                lane          <= '0;
                obeat         <= '0;
                rptr          <= AW'(2);
            end
            if (beat_end) begin
                hold  <= rd_q;
                obeat <= obeat + ONE;
                rptr  <= rptr + AW'(1);
            end
            if (fire) lane <= beat_end ? '0 : lane + LW'(1);
            if (done_n) m_axis_tvalid <= 1'b0;
        end
    end

    // Simple-dual-port buffer with registered read
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= s_axis_tdata;
        if (re) rd_q <= mem[raddr];
    end
endmodule

// File: tb/tb_adc_capture_dma_tx.sv
// tb_adc_capture_dma_tx: randomized bench with a packet-level reference model for adc_capture_dma_tx
module tb_adc_capture_dma_tx;
    localparam int LANES = 8;
    localparam int DEPTH = 256;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trig = 1'b0;
    logic [AW:0] cfg_len = '0;
    logic [16*LANES-1:0] s_tdata = '0;
    logic s_tvalid = 1'b0;
    logic s_tready;
    logic [15:0] m_tdata;
    logic m_tvalid;
    logic m_tready = 1'b1;
    logic m_tlast, busy, done, trig_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_pct = 100;
    int pkt_words = 0;
    int last_words = 0;
    int first_v = 0;
    int last_hs = 0;
    int lastwr_n = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rec_q[$];
    bit m_active = 0;
    bit exp_done = 0;
    bit exp_err = 0;
    bit prev_stall = 0;
    bit pkt_first = 0;
    logic prev_l;
    logic [15:0] prev_d;

    adc_capture_dma_tx #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .trig(trig), .cfg_len(cfg_len),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .busy(busy), .done(done), .trig_err(trig_err)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = ($urandom_range(99) < rdy_pct);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic logic [16*LANES-1:0] rand_beat();
        logic [16*LANES-1:0] r;
        for (int k = 0; k < LANES / 2; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [16*LANES-1:0] pat_beat(input int b);
        logic [16*LANES-1:0] r;
        for (int k = 0; k < LANES; k++) r[16*k +: 16] = 16'(256 * (b + 1) + k);
        return r;
    endfunction

    // Reference model: the packet is the first min(len,DEPTH) valid beats after the trigger, lane 0 first
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_active = 0;
            exp_done = 0;
            exp_err = 0;
            prev_stall = 0;
            pkt_first = 0;
        end else begin
            chk("tready", 32'(s_tready), 32'd1);
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(exp_done));
            chk("trig_err", 32'(trig_err), 32'(exp_err));
            if (exp_done) chk("valid_after_last", 32'(m_tvalid), 32'd0);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'(m_tdata), 32'(prev_d));
                chk("hold_last", 32'(m_tlast), 32'(prev_l));
            end
            if (m_tvalid && pkt_first) begin
                chk("latency", cyc, lastwr_n + 2);
                first_v = cyc;
                pkt_first = 0;
            end
            exp_done = 0;
            exp_err = trig && (m_active || cfg_len == '0);
            if (trig && !m_active && cfg_len != '0) begin
                m_active = 1;
                pkt_first = 1;
                pkt_words = 0;
                rec_q.delete();
            end
            if (m_tvalid && exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got tvalid=1 want 0 (cycle %0d)", cyc);
            end else if (m_tvalid && m_tready) begin
                chk("tdata", 32'(m_tdata), 32'(exp_q[0]));
                chk("tlast", 32'(m_tlast), 32'(exp_q.size() == 1));
                void'(exp_q.pop_front());
                rec_q.push_back(m_tdata);
                pkt_words++;
                if (exp_q.size() == 0) begin
                    m_active = 0;
                    exp_done = 1;
                    last_words = pkt_words;
                    last_hs = cyc;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end
    end

    task automatic recover();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 5000 && m_active; k++) begin
            @(posedge clk);
            #1;
        end
        if (m_active) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy packet want idle (cycle %0d)", cyc);
            recover();
        end
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random; btrig injects triggers in CAPTURE and DRAIN
    task automatic run_pkt(input int len_cfg, input int vmode, input bit btrig, input int rst_after, input bit pat);
        logic [16*LANES-1:0] beat;
        logic v;
        int eff, cnt, it;
        wait_idle();
        eff = (len_cfg > DEPTH) ? DEPTH : len_cfg;
        cfg_len = (AW+1)'(len_cfg);
        trig = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = rand_beat();
        @(posedge clk);
        #1;
        trig = 1'b0;
        cfg_len = (AW+1)'($urandom);
        cnt = 0;
        it = 0;
        while (cnt < eff) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (it % 2 == 0) : 1'($urandom_range(1));
            beat = pat ? pat_beat(cnt) : rand_beat();
            s_tvalid = v;
            s_tdata = beat;
            trig = btrig && it == 0;
            if (v) begin
                for (int k = 0; k < LANES; k++) exp_q.push_back(beat[16*k +: 16]);
                cnt++;
                if (cnt == eff) lastwr_n = cyc;
            end
            it++;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 20000 && m_active; k++) begin
            s_tvalid = 1'($urandom_range(1));
            s_tdata = rand_beat();
            trig = btrig && k == 2;
            if (rst_after > 0 && pkt_words == rst_after) begin
                rst = 1'b1;
                trig = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        trig = 1'b0;
        s_tvalid = 1'b0;
        if (m_active) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words want %0d (cycle %0d)", pkt_words, eff * LANES, cyc);
            recover();
        end
    endtask

    task automatic trig_zero();
        wait_idle();
        cfg_len = '0;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        @(negedge clk);
        chk("zero_err", 32'(trig_err), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_novalid", 32'(m_tvalid), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig_err", 32'(trig_err), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_pkt(2, 0, 0, 0, 1);
        chk("basic_words", 32'(rec_q.size()), 32'd16);
        chk("basic_w0", 32'(rec_q[0]), 32'h0100);
        chk("basic_w7", 32'(rec_q[7]), 32'h0107);
        chk("basic_w8", 32'(rec_q[8]), 32'h0200);
        chk("basic_w15", 32'(rec_q[15]), 32'h0207);
        chk("basic_rate", last_hs - first_v, 15);

        rdy_pct = 50;
        run_pkt(3, 1, 0, 0, 0);
        chk("gap_words", last_words, 24);

        rdy_pct = 70;
        run_pkt(4, 2, 1, 0, 0);
        chk("busy_trig_words", last_words, 32);

        trig_zero();

        rdy_pct = 100;
        run_pkt(300, 0, 0, 0, 0);
        chk("len300_words", last_words, 2048);

        run_pkt(4, 0, 0, 5, 0);
        @(negedge clk);
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        run_pkt(1, 2, 0, 0, 0);
        chk("post_rst_words", last_words, 8);

        for (int p = 0; p < 14; p++) begin
            rdy_pct = $urandom_range(30, 100);
            if ($urandom_range(4) == 0) trig_zero();
            run_pkt($urandom_range(1, 20), $urandom_range(2), 1'($urandom_range(1)), 0, 0);
        end

        wait_idle();
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
